// File: rtl/pi_link_pkg.sv
// Shared types and sizing for the Raspberry Pi -> FPGA parallel byte link.
package pi_link_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_LOW = 2'd1,
    ERR      = 2'd2
  } rx_state_e;

  localparam int PI_BYTE_W          = 8;
  localparam int BYTE_CNT_W         = 16;
  localparam int DEF_FIFO_DEPTH     = 8;
  localparam int DEF_TIMEOUT_CYCLES = 1000000;

endpackage

// File: rtl/byte_fifo.sv
// First-word-fall-through FIFO with synchronous reset; head entry is visible
// on pop_data whenever count is non-zero.
module byte_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             push_s;
  logic             pop_s;

  // Full/empty come from the pre-edge count, so a pop never frees a slot for a same-cycle push.
  assign full     = (count_r == CNT_W'(DEPTH));
  assign empty    = (count_r == {CNT_W{1'b0}});
  assign push_s   = push && !full;
  assign pop_s    = pop && !empty;
  assign pop_data = mem_r[rd_ptr_r];
  assign count    = count_r;

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap at the power-of-two depth.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/pi_byte_rx_ctrl.sv
// Receive controller for the Pi parallel byte link: four-phase handshake,
// FIFO buffering with backpressure, handshake timeout and byte counting.
module pi_byte_rx_ctrl
  import pi_link_pkg::*;
#(
  parameter int FIFO_DEPTH     = DEF_FIFO_DEPTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pi_hsk_raw,
  input  logic [PI_BYTE_W-1:0]  PMOD,
  output logic                  fpga_hsk,
  output logic [PI_BYTE_W-1:0]  out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  input  logic                  err_clr,
  output logic                  timeout_err,
  output logic [BYTE_CNT_W-1:0] byte_count
);

  localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int TMO_W      = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  rx_state_e             state_r;
  logic                  sync1_r;
  logic                  sync2_r;
  logic                  pi_hsk_s;
  logic                  fpga_hsk_r;
  logic                  timeout_err_r;
  logic [BYTE_CNT_W-1:0] byte_count_r;
  logic [TMO_W-1:0]      tmo_cnt_r;
  logic                  push_s;
  logic                  pop_s;
  logic                  fifo_full_s;
  logic                  fifo_empty_s;
  logic [FIFO_CNT_W-1:0] fifo_count_s;

  // Two-flop synchronizer for the asynchronous Pi request.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= pi_hsk_raw;
      sync2_r <= sync1_r;
    end
  end

  assign pi_hsk_s = sync2_r;
  // PMOD is sampled unsynchronized here; the Pi holds it stable until fpga_hsk rises.
  assign push_s   = (state_r == IDLE) && pi_hsk_s && !fifo_full_s;
  assign pop_s    = out_ready && !fifo_empty_s;

  // Handshake FSM with timeout counter, sticky error flag and accepted-byte counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= IDLE;
      fpga_hsk_r    <= 1'b0;
      timeout_err_r <= 1'b0;
      byte_count_r  <= {BYTE_CNT_W{1'b0}};
      tmo_cnt_r     <= {TMO_W{1'b0}};
    end else begin
      // Cleared first so a timeout on the same edge overrides the clear.
      if (err_clr) begin
        timeout_err_r <= 1'b0;
      end
      case (state_r)
        IDLE: begin
          if (push_s) begin
            fpga_hsk_r   <= 1'b1;
            byte_count_r <= byte_count_r + 16'd1;
            tmo_cnt_r    <= {TMO_W{1'b0}};
            state_r      <= WAIT_LOW;
          end
        end
        WAIT_LOW: begin
          if (!pi_hsk_s) begin
            fpga_hsk_r <= 1'b0;
            state_r    <= IDLE;
          end else if (tmo_cnt_r == TMO_LAST) begin
            fpga_hsk_r    <= 1'b0;
            timeout_err_r <= 1'b1;
            state_r       <= ERR;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
          end
        end
        ERR: begin
          if (!pi_hsk_s) begin
            state_r <= IDLE;
          end
        end
        default: begin
          fpga_hsk_r <= 1'b0;
          state_r    <= IDLE;
        end
      endcase
    end
  end

  byte_fifo #(
    .WIDTH (PI_BYTE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_s),
    .push_data (PMOD),
    .pop       (pop_s),
    .pop_data  (out_data),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .count     (fifo_count_s)
  );

  assign out_valid   = (fifo_count_s != {FIFO_CNT_W{1'b0}});
  assign fpga_hsk    = fpga_hsk_r;
  assign timeout_err = timeout_err_r;
  assign byte_count  = byte_count_r;

endmodule

// File: doc/pi_byte_rx_ctrl.md
# pi_byte_rx_ctrl

Receive-side controller for the Raspberry Pi → FPGA parallel byte link on the PMOD header. Sequences the four-phase handshake on `pi_hsk_raw`/`fpga_hsk`, captures each `PMOD` byte into an internal FIFO, and presents the bytes to the FPGA datapath over a valid/ready stream. The controller applies backpressure to the Pi by withholding the acknowledge while the FIFO is full. It also flags a Pi that never completes the handshake.

## Interface
- `FIFO_DEPTH`, default 8: byte FIFO depth; power of two, ≥2.
- `TIMEOUT_CYCLES`, default 1000000: number of `clk` cycles allowed in WAIT_LOW before an error is declared; ≥2.
- `clk` in 1: single clock for the block.
- `reset` in 1: **synchronous, active-high** reset.
- `pi_hsk_raw` in 1: Pi request, asynchronous.
- `PMOD` in 8: Pi data byte; stable while `pi_hsk_raw` is high.
- `fpga_hsk` out 1: acknowledge to Pi, registered.
- `out_data` out 8: head-of-FIFO byte.
- `out_valid` out 1: FIFO non-empty.
- `out_ready` in 1: consumer accepts `out_data` when `out_valid` is also high.
- `err_clr` in 1: clears `timeout_err`.
- `timeout_err` out 1: sticky handshake-timeout flag.
- `byte_count` out 16: count of accepted bytes; wraps from 0xFFFF to 0.

## Operation
- `pi_hsk_raw` passes through a 2-flop synchronizer to produce `pi_hsk`. Both flops reset to 0.
- `PMOD` is not synchronized. It is sampled directly on the accept edge. The Pi holds it stable from before the `pi_hsk_raw` rise until `fpga_hsk` rises.
- **IDLE** (`fpga_hsk`=0):
  - If `pi_hsk`=1 and the FIFO is not full: push `PMOD`, set `fpga_hsk`←1, increment `byte_count`, clear the timeout counter, go to WAIT_LOW.
  - If the FIFO is full: remain in IDLE with `fpga_hsk`=0. This is the backpressure mechanism.
- **WAIT_LOW** (`fpga_hsk`=1):
  - If `pi_hsk`=0: set `fpga_hsk`←0 and go to IDLE.
  - Otherwise increment the timeout counter. When the counter reaches `TIMEOUT_CYCLES`−1 with `pi_hsk` still 1: set `fpga_hsk`←0, set `timeout_err`←1, go to ERR.
- **ERR** (`fpga_hsk`=0): wait for `pi_hsk`=0, then go to IDLE. No byte is accepted while in ERR.
- `timeout_err` stays set until `err_clr`=1. If a timeout and `err_clr` occur in the same cycle, the set wins.
- FIFO is first-word fall-through:
  - `out_valid` = (count≠0).
  - `out_data` = entry at the read pointer.
  - A pop occurs on `out_valid && out_ready`.
- Full is evaluated on the pre-edge count. A pop does not free a slot for a push in the same cycle.
- Simultaneous push and pop when not full: count is unchanged and both pointers advance. Pointers wrap modulo `FIFO_DEPTH`.
- Reset, at any point including mid-handshake:
  - state←IDLE, FIFO emptied, sync flops←0.
  - `fpga_hsk`=0, `out_valid`=0, `timeout_err`=0, `byte_count`=0.
  - `out_data` is don't-care while `out_valid`=0.
- A `pi_hsk_raw` still high after reset is treated as a fresh byte. The Pi retransmits after an FPGA reset.

## Timing
- `pi_hsk_raw` rises before edge E0. `pi_hsk`=1 after E1.
- At E2, if in IDLE and not full: byte is pushed and `fpga_hsk`=1. `out_valid`=1 after E2 if the FIFO was empty.
- Latency from `pi_hsk_raw` rise to `fpga_hsk` rise: 3 edges, counting E0.
- `pi_hsk_raw` falls before edge F0. `fpga_hsk`=0 after F2.
- Minimum full transfer: 6 cycles per byte.
- Timeout fires exactly `TIMEOUT_CYCLES` cycles after entering WAIT_LOW, if `pi_hsk` never falls.
- `byte_count` updates on the same edge as the push.

## Structure
- Package `pi_link_pkg` contains:
  - state enum {IDLE, WAIT_LOW, ERR};
  - `PI_BYTE_W`=8, `BYTE_CNT_W`=16;
  - default `FIFO_DEPTH` and `TIMEOUT_CYCLES`.
- Sub-module `byte_fifo`, parameterized by width and depth: synchronous reset, FWFT, outputs full/empty/count.
- The synchronizer, FSM, timeout counter and `byte_count` are inline in `pi_byte_rx_ctrl`.

## Test plan
- **Single byte:** `PMOD`=0xA5, raise `pi_hsk_raw`; hold `out_ready`=0 → `fpga_hsk` rises 3 edges later; `out_valid`=1, `out_data`=0xA5, `byte_count`=1. Drop `pi_hsk_raw` → `fpga_hsk`=0 after 3 edges.
- **Backpressure:** with `FIFO_DEPTH`=8 and `out_ready`=0, send 0x00..0x08 → 8 bytes acked; 9th leaves `fpga_hsk`=0. Pulse `out_ready` for 1 cycle → 0x00 popped, 0x08 acked next cycle. Drain order is 0x01..0x08.
- **Timeout:** `TIMEOUT_CYCLES`=16, `pi_hsk_raw` held high → `fpga_hsk` drops and `timeout_err`=1 after 16 WAIT_LOW cycles. No new byte until `pi_hsk_raw` goes low and high again. `err_clr` → `timeout_err`=0.
- **Streaming:** 20 random bytes with `out_ready`=1 → output sequence matches input exactly; `byte_count`=20.
- **Reset mid-handshake:** `reset` asserted in WAIT_LOW with 3 bytes queued → next cycle `fpga_hsk`=0, `out_valid`=0, `byte_count`=0. `pi_hsk_raw` still high → accepted as a new byte after release.
- **Wrap:** force 65 536 transfers, or preload via bind → `byte_count` wraps 0xFFFF→0x0000.
